// File: rtl/rom_addr_seq_pkg.sv
// Shared constants for the PROM address sequencer.
// Op encodings and default geometry.
package rom_addr_seq_pkg;

  localparam logic [1:0] OP_CONT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam int WIDTH_DEF  = 4;
  localparam int HEIGHT_DEF = 9;
  localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/rom_addr_stack.sv
// Return-address LIFO for rom_addr_seq.
// Push is dropped when full, pop when empty.
module rom_addr_stack
  import rom_addr_seq_pkg::*;
#(
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [HEIGHT-1:0] din,
  output logic [HEIGHT-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + 1);

  logic [SW-1:0]     sp;
  logic [HEIGHT-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (sp == '0);
  assign full    = (sp == SW'(DEPTH));
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (clr) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + SW'(1);
    end else if (do_pop) begin
      sp <= sp - SW'(1);
    end
  end

  // Entries are left unreset; dout masks them while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[AW'(sp)] <= din;
    end
  end

  assign dout = empty ? '0 : mem[AW'(sp - SW'(1))];

endmodule

// File: rtl/rom_addr_seq.sv
// Microprogram address sequencer with call stack
// and PROM pipeline register.
module rom_addr_seq
  import rom_addr_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [1:0]        op,
  input  logic [HEIGHT-1:0] d,
  input  logic              zero_,
  input  logic [WIDTH-1:0]  q,
  output logic [HEIGHT-1:0] a,
  output logic [WIDTH-1:0]  pl,
  output logic              empty,
  output logic              full,
  output logic              err
);

  logic [HEIGHT-1:0] ar;
  logic [HEIGHT-1:0] ar_nxt;
  logic [HEIGHT-1:0] ar_inc;
  logic [HEIGHT-1:0] tos;
  logic              push;
  logic              pop;
  logic              clr;
  logic              err_set;

  assign a      = ar;
  assign ar_inc = ar + HEIGHT'(1);

  always_comb begin
    ar_nxt  = ar;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    err_set = 1'b0;
    if (ce) begin
      if (!zero_) begin
        ar_nxt = '0;
        clr    = 1'b1;
      end else begin
        unique case (op)
          OP_CONT: ar_nxt = ar_inc;
          OP_JUMP: ar_nxt = d;
          OP_CALL: begin
            ar_nxt  = d;
            push    = !full;
            err_set = full;
          end
          OP_RET: begin
            ar_nxt  = tos;
            pop     = !empty;
            err_set = empty;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar <= '0;
      pl <= '0;
    end else if (ce) begin
      ar <= ar_nxt;
      pl <= q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  rom_addr_stack #(
    .HEIGHT(HEIGHT),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .push (push),
    .pop  (pop),
    .din  (ar_inc),
    .dout (tos),
    .empty(empty),
    .full (full)
  );

endmodule

// File: tb/tb_rom_addr_seq.sv
// Bench for rom_addr_seq: directed scenarios plus random ops
// against a queue-based reference model and a 512x4 PROM.
module tb_rom_addr_seq;
  import rom_addr_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [1:0] op;
  logic [8:0] d;
  logic       zero_;
  logic [3:0] q;
  logic [8:0] a;
  logic [3:0] pl;
  logic       empty;
  logic       full;
  logic       err;

  logic [3:0] prom [512];
  assign q = prom[a];

  int total = 0;
  int bad   = 0;

  logic [8:0] m_ar;
  logic [3:0] m_pl;
  logic       m_err;
  logic [8:0] m_stk [$];

  rom_addr_seq dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .op   (op),
    .d    (d),
    .zero_(zero_),
    .q    (q),
    .a    (a),
    .pl   (pl),
    .empty(empty),
    .full (full),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ar  = '0;
    m_pl  = '0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a"}, 16'(a), 16'(m_ar));
    chk({tag, ".pl"}, 16'(pl), 16'(m_pl));
    chk({tag, ".empty"}, 16'(empty),
        16'(m_stk.size() == 0));
    chk({tag, ".full"}, 16'(full),
        16'(m_stk.size() == DEPTH_DEF));
    chk({tag, ".err"}, 16'(err), 16'(m_err));
  endtask

  task automatic step(input string tag,
                      input logic c,
                      input logic [1:0] o,
                      input logic [8:0] dv,
                      input logic z);
    ce    = c;
    op    = o;
    d     = dv;
    zero_ = z;
    @(posedge clk);
    if (c) begin
      m_pl = prom[m_ar];
      if (!z) begin
        m_ar = '0;
        m_stk.delete();
      end else begin
        case (o)
          OP_CONT: m_ar = m_ar + 9'd1;
          OP_JUMP: m_ar = dv;
          OP_CALL: begin
            if (m_stk.size() == DEPTH_DEF) m_err = 1'b1;
            else m_stk.push_back(m_ar + 9'd1);
            m_ar = dv;
          end
          default: begin
            if (m_stk.size() == 0) begin
              m_ar  = '0;
              m_err = 1'b1;
            end else begin
              m_ar = m_stk.pop_back();
            end
          end
        endcase
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) prom[i] = 4'($urandom);
    rst   = 1'b1;
    ce    = 1'b1;
    op    = OP_CONT;
    d     = '0;
    zero_ = 1'b1;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // async reset mid-run with stack and err populated
    step("pre_ret", 1, OP_RET, 9'h000, 1);
    step("pre_jmp", 1, OP_JUMP, 9'h0A0, 1);
    step("pre_call", 1, OP_CALL, 9'h0A5, 1);
    chk("pre_rst.a", 16'(a), 16'h0A5);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1 rst = 1'b0;

    // wrap-around with pipeline lag
    step("w_jmp", 1, OP_JUMP, 9'h1FE, 1);
    step("w_c1", 1, OP_CONT, 9'h000, 1);
    chk("w_c1.a", 16'(a), 16'h1FF);
    step("w_c2", 1, OP_CONT, 9'h000, 1);
    chk("w_c2.a", 16'(a), 16'h000);
    chk("w_c2.pl", 16'(pl), 16'(prom[9'h1FF]));
    step("w_c3", 1, OP_CONT, 9'h000, 1);
    chk("w_c3.a", 16'(a), 16'h001);
    chk("w_c3.pl", 16'(pl), 16'(prom[9'h000]));

    // call / cont / return
    step("cr_jmp", 1, OP_JUMP, 9'h010, 1);
    step("cr_call", 1, OP_CALL, 9'h040, 1);
    chk("cr_call.a", 16'(a), 16'h040);
    step("cr_cont", 1, OP_CONT, 9'h000, 1);
    chk("cr_cont.a", 16'(a), 16'h041);
    step("cr_ret", 1, OP_RET, 9'h000, 1);
    chk("cr_ret.a", 16'(a), 16'h011);
    chk("cr_ret.empty", 16'(empty), 16'h1);

    // overflow then unwind
    for (int i = 0; i < 5; i++) begin
      step("ov_call", 1, OP_CALL, 9'(9'h100 + i), 1);
      if (i == 3) chk("ov_full", 16'(full), 16'h1);
      if (i == 4) begin
        chk("ov_err", 16'(err), 16'h1);
        chk("ov_a", 16'(a), 16'h104);
      end
    end
    for (int i = 0; i < 4; i++)
      step("ov_ret", 1, OP_RET, 9'h000, 1);
    chk("ov_ret.a", 16'(a), 16'h012);
    chk("ov_ret.empty", 16'(empty), 16'h1);

    // underflow, sticky err through zero_
    step("un_jmp", 1, OP_JUMP, 9'h077, 1);
    step("un_ret", 1, OP_RET, 9'h000, 1);
    chk("un_ret.a", 16'(a), 16'h000);
    step("un_call", 1, OP_CALL, 9'h055, 1);
    step("un_zero", 1, OP_CONT, 9'h000, 0);
    chk("un_zero.err", 16'(err), 16'h1);
    chk("un_zero.empty", 16'(empty), 16'h1);

    // clock enable low holds everything
    step("ce_jmp", 1, OP_JUMP, 9'h033, 1);
    step("ce_call", 1, OP_CALL, 9'h034, 1);
    for (int i = 0; i < 3; i++)
      step("ce_off", 0, OP_JUMP, 9'h123, 1);
    step("ce_offz", 0, OP_CONT, 9'h000, 0);
    chk("ce_off.a", 16'(a), 16'h034);
    step("ce_on", 1, OP_JUMP, 9'h123, 1);
    chk("ce_on.a", 16'(a), 16'h123);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step("rnd",
           logic'($urandom_range(0, 7) != 0),
           2'($urandom_range(0, 3)),
           9'($urandom),
           logic'($urandom_range(0, 19) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
